// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with prescaler, parallel load and tick/wrap/load_err pulses.
// q and the pulses are registered and update on the edge that steps or loads; there is no backpressure.
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tick,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    q_q, q_d;
    logic [31:0]     presc_q, presc_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;

    logic [W-1:0]    step_val;
    logic [DIGITS:0] carry;
    logic            step;
    logic            load_ok;

    // Ripple carry (up) or borrow (down) across digits; carry out of the top digit is the wrap.
    always_comb begin
        step_val = q_q;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            carry[i+1] = 1'b0;
            if (carry[i]) begin
                if (up_dn) begin
                    if (q_q[4*i +: 4] >= 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                        carry[i+1]         = 1'b1;
                    end else begin
                        step_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
                    end
                end else begin
                    if (q_q[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                        carry[i+1]         = 1'b1;
                    end else begin
                        step_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    assign step = en && (presc_q == 32'(TICK_DIV));

    always_comb begin
        q_d     = q_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            // A rejected load leaves both count and prescaler phase untouched.
            if (load_ok) begin
                q_d     = load_val;
                presc_d = '0;
            end else begin
                err_d   = 1'b1;
            end
        end else if (step) begin
            q_d     = step_val;
            presc_d = '0;
            tick_d  = 1'b1;
            wrap_d  = carry[DIGITS];
        end else if (en) begin
            presc_d = presc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign q        = q_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter with DIGITS=2, TICK_DIV=1.
module tb_bcd_updown_counter;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] q;
    logic       tick;
    logic       wrap;
    logic       load_err;

    always #5 clk = ~clk;

    bcd_updown_counter #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tick     (tick),
        .wrap     (wrap),
        .load_err (load_err)
    );

    typedef struct packed {
        logic [7:0] q;
        logic       tick;
        logic       wrap;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_q      = 0;
    int   m_pre    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Drive one clock of stimulus, predict the result, then compare after the edge.
    task automatic cycle(input logic r, input logic e, input logic ud, input logic ld,
                         input logic [7:0] lv);
        exp_t x;
        reset    = r;
        en       = e;
        up_dn    = ud;
        load     = ld;
        load_val = lv;
        x.tick   = 1'b0;
        x.wrap   = 1'b0;
        x.err    = 1'b0;
        if (r) begin
            m_q   = 0;
            m_pre = 0;
        end else if (ld) begin
            if (lv[3:0] <= 4'd9 && lv[7:4] <= 4'd9) begin
                m_q   = int'(lv[7:4]) * 10 + int'(lv[3:0]);
                m_pre = 0;
            end else begin
                x.err = 1'b1;
            end
        end else if (e) begin
            if (m_pre == TICK_DIV) begin
                m_pre  = 0;
                x.tick = 1'b1;
                if (ud) begin
                    x.wrap = (m_q == 99);
                    m_q    = (m_q + 1) % 100;
                end else begin
                    x.wrap = (m_q == 0);
                    m_q    = (m_q + 99) % 100;
                end
            end else begin
                m_pre++;
            end
        end
        x.q = to_bcd(m_q);
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            check_eq("q", q, x.q);
            check_eq("tick", tick, x.tick);
            check_eq("wrap", wrap, x.wrap);
            check_eq("load_err", load_err, x.err);
        end
    endtask

    initial begin
        cycle(1, 0, 1, 0, 8'h00);
        cycle(1, 0, 1, 0, 8'h00);
        check_eq("reset_q", q, 8'h00);

        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 8'h00);
        check_eq("up_seq_q", q, 8'h04);

        cycle(0, 0, 1, 1, 8'h99);
        cycle(0, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 0, 8'h00);
        check_eq("wrap_up_q", q, 8'h00);
        check_eq("wrap_up_flag", wrap, 1);
        check_eq("wrap_up_tick", tick, 1);
        cycle(0, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 0, 8'h00);
        check_eq("after_wrap_q", q, 8'h01);
        check_eq("after_wrap_flag", wrap, 0);

        cycle(0, 0, 0, 1, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);
        check_eq("wrap_dn_q", q, 8'h99);
        check_eq("wrap_dn_flag", wrap, 1);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);
        check_eq("dn_98", q, 8'h98);
        cycle(0, 0, 0, 1, 8'h10);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);
        check_eq("borrow_q", q, 8'h09);

        cycle(0, 0, 1, 1, 8'h42);
        cycle(0, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 8'h3A);
        check_eq("bad_load_q", q, 8'h42);
        check_eq("bad_load_err", load_err, 1);
        cycle(0, 1, 1, 0, 8'h00);
        check_eq("bad_load_phase_q", q, 8'h43);
        check_eq("bad_load_err_clr", load_err, 0);

        cycle(0, 1, 1, 0, 8'h00);
        cycle(0, 0, 1, 0, 8'h00);
        check_eq("en_off_tick", tick, 0);
        cycle(0, 0, 1, 0, 8'h00);
        cycle(0, 1, 1, 0, 8'h00);
        check_eq("en_resume_q", q, 8'h44);
        check_eq("en_resume_tick", tick, 1);

        cycle(0, 0, 1, 1, 8'h57);
        cycle(0, 1, 1, 0, 8'h00);
        cycle(1, 1, 1, 0, 8'h00);
        check_eq("mid_reset_q", q, 8'h00);
        check_eq("mid_reset_tick", tick, 0);
        cycle(0, 1, 1, 0, 8'h00);
        check_eq("post_reset_nostep", tick, 0);
        cycle(0, 1, 1, 0, 8'h00);
        check_eq("post_reset_step_q", q, 8'h01);

        cycle(1, 0, 1, 1, 8'h55);
        check_eq("reset_over_load_q", q, 8'h00);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 60) == 0, ($urandom % 4) != 0, 1'($urandom),
                  ($urandom % 10) == 0, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
